wb_unit: RTL and testbench
==========================

Name: wb_unit

Overview:
- Write-back stage of the 16-bit pipelined core; drives the register-file write port and the MEM/WB destination tag consumed by decode-stage hazard detection.
- Holds the MEM/WB pipeline register.
- Selects write data from the ALU result, load data, or call link address.
- After reset, runs an init sequence that loads the stack pointer before accepting instructions; the decode stage's regfile needs no reset mux.

Parameters:
- DATA_W, 16, datapath width.
- SP_IDX, 4'hF, register index of the stack pointer.
- SP_RESET, 16'hFFFF, value written to SP during init.
- LINK_INC, 1, offset added to PC for the call link value.

Ports:
- clk  in  1  global clock
- rst  in  1  reset; asynchronous, active-low
- mem_valid  in  1  MEM stage presents a retiring instruction
- wb_ready  out  1  stage can accept; low during init
- reg_write_in  in  1  instruction writes a register
- mem_to_reg_in  in  1  select load data
- call_in  in  1  select PC+LINK_INC (call link)
- reg_rd_in  in  4  destination register
- alu_result_in  in  DATA_W  ALU result
- mem_data_in  in  DATA_W  load data
- PC_in  in  16  PC of the instruction
- reg_write  out  1  regfile write enable
- reg_rd_wb  out  4  regfile write index
- reg_rd_data  out  DATA_W  regfile write data
- MEM_WB_reg_rd  out  4  hazard tag; 4'h0 when no pending write
- init_done  out  1  init sequence complete
- retired_count  out  16  count of retired instructions

Behaviour:
- Reset (rst=0, async):
  - state=INIT_SP; pipeline register valid_q=0 and all fields 0.
  - retired_count=0, init_done=0, wb_ready=0.
  - reg_write=1, reg_rd_wb=SP_IDX, reg_rd_data=SP_RESET. This is combinational from state, so the SP write is presented while in reset.
- State machine: INIT_SP -> (CLEAR when REGFILE_CLEAR_EN) -> RUN.
  - INIT_SP lasts exactly one clock edge after rst deasserts.
  - RUN is absorbing until reset.
- Ready and capture:
  - wb_ready=1 only in RUN.
  - Capture on a clk edge when mem_valid && wb_ready: valid_q<=1 and all fields latched.
  - With mem_valid=0 in RUN: valid_q<=0.
  - mem_valid while not ready is ignored; upstream must hold.
- Outputs in RUN (registered fields, one-cycle latency from capture):
  - reg_write = valid_q && reg_write_q && (rd_q != 0). R0 is hardwired zero and its writes are suppressed.
  - reg_rd_wb = rd_q.
  - reg_rd_data priority: call_q -> PC_q+LINK_INC (mod 2^16); else mem_to_reg_q -> mem_data_q; else alu_q.
  - MEM_WB_reg_rd = reg_write ? rd_q : 4'h0.
- When both call_q and mem_to_reg_q are set, call wins.
- retired_count:
  - Increments on each edge where valid_q=1 in RUN, including non-writing instructions.
  - Saturates at 16'hFFFF.
- init_done=1 iff state==RUN.
- Reset mid-operation: valid_q is discarded immediately, no partial write occurs, and the init sequence restarts.

Optional Feature:
- Macro: WB_REGFILE_CLEAR_EN.
- Defined: after INIT_SP, state CLEAR walks an index 1..14, writing 16'h0000 to one register per cycle (14 cycles). Then RUN. Total wb_ready delay: 15 cycles after reset release.
- Undefined: INIT_SP -> RUN directly; register contents are undefined except SP.

Decomposition:
- Shared package core_pkg:
  - wb_state_t enum {INIT_SP, CLEAR, RUN}
  - REG_ZERO=4'h0
  - SP_IDX_C=4'hF
  - SP_RESET_C=16'hFFFF
- One natural sub-module: wb_data_sel, the combinational priority mux (call/load/alu) including the PC+LINK_INC adder.

Test Plan:
- Reset release, feature off -> during reset reg_write=1, reg_rd_wb=F, data=FFFF; first edge after release init_done=1, wb_ready=1.
- Capture ALU op rd=3, alu=0x1234, mem_valid=1 -> next cycle reg_write=1, reg_rd_wb=3, data=0x1234, MEM_WB_reg_rd=3; retired_count=1 after the following edge.
- Load rd=5, mem_to_reg=1, mem_data=0xBEEF, alu=0x1111 -> data=0xBEEF. Call with PC=0xFFFF, rd=E -> data=0x0000 (wrap).
- Write to rd=0, or reg_write_in=0 -> reg_write=0, MEM_WB_reg_rd=0, retired_count still increments; saturation: preload 0xFFFE, retire 3 -> holds 0xFFFF.
- Assert rst low mid-stream with valid_q=1 -> same cycle reg_rd_wb=F, data=FFFF, wb_ready=0; the pending instruction is never written.
- WB_REGFILE_CLEAR_EN defined -> writes F, then 1..14 with 0x0000 on consecutive cycles; wb_ready rises exactly 15 edges after release; mem_valid held meanwhile is accepted on the first ready edge.

Source files
------------

// File: rtl/core_pkg.sv
// core_pkg: shared write-back types and constants.
// Holds the write-back FSM state enum, the zero-register index, and the
// stack pointer index and reset value.
package core_pkg;
    typedef enum logic [1:0] {INIT_SP, CLEAR, RUN} wb_state_t;
    localparam logic [3:0]  REG_ZERO   = 4'h0;
    localparam logic [3:0]  SP_IDX_C   = 4'hF;
    localparam logic [15:0] SP_RESET_C = 16'hFFFF;
endpackage

// File: rtl/wb_data_sel.sv
// wb_data_sel: write-back data priority mux.
// Priority is call link (pc + LINK_INC), then load data, then ALU result.
// Ports: call, mem_to_reg (selects); pc, mem_data, alu (sources); data (result).
module wb_data_sel #(
    parameter int DATA_W   = 16,
    parameter int LINK_INC = 1
) (
    input  logic              call,
    input  logic              mem_to_reg,
    input  logic [15:0]       pc,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] alu,
    output logic [DATA_W-1:0] data
);
    logic [15:0] link;
    // The link address wraps modulo 2^16.
    assign link = pc + 16'(LINK_INC);
    assign data = call ? DATA_W'(link) : mem_to_reg ? mem_data : alu;
endmodule

// File: rtl/wb_unit.sv
// wb_unit: write-back stage holding the MEM/WB register and driving the regfile write port.
// After reset it writes SP_RESET to SP_IDX. When WB_REGFILE_CLEAR_EN is defined, it then
// zeroes registers 1..14, one per cycle. Only after that does it accept instructions.
// Ports: clk, rst (async, active-low); mem_valid/wb_ready handshake; *_in MEM-stage fields;
//        reg_write/reg_rd_wb/reg_rd_data regfile port; MEM_WB_reg_rd hazard tag;
//        init_done; retired_count (saturating).
// Build macro: WB_REGFILE_CLEAR_EN enables the register clear walk.
module wb_unit
    import core_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter logic [3:0]      SP_IDX   = SP_IDX_C,
    parameter logic [DATA_W-1:0] SP_RESET = SP_RESET_C,
    parameter int              LINK_INC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_valid,
    output logic              wb_ready,
    input  logic              reg_write_in,
    input  logic              mem_to_reg_in,
    input  logic              call_in,
    input  logic [3:0]        reg_rd_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] mem_data_in,
    input  logic [15:0]       PC_in,
    output logic              reg_write,
    output logic [3:0]        reg_rd_wb,
    output logic [DATA_W-1:0] reg_rd_data,
    output logic [3:0]        MEM_WB_reg_rd,
    output logic              init_done,
    output logic [15:0]       retired_count
);
    wb_state_t         state, state_n;
    logic              valid_q, we_q, m2r_q, call_q;
    logic [3:0]        rd_q;
    logic [DATA_W-1:0] alu_q, mem_q, sel_data;
    logic [15:0]       pc_q, cnt_q;
    logic              pipe_we;
`ifdef WB_REGFILE_CLEAR_EN
    logic [3:0]        idx_q, idx_n;
`endif

    wb_data_sel #(.DATA_W(DATA_W), .LINK_INC(LINK_INC)) u_sel (
        .call       (call_q),
        .mem_to_reg (m2r_q),
        .pc         (pc_q),
        .mem_data   (mem_q),
        .alu        (alu_q),
        .data       (sel_data)
    );

    // R0 is hardwired zero, so its writes never reach the regfile or the hazard tag.
    assign pipe_we       = valid_q && we_q && (rd_q != REG_ZERO);
    assign MEM_WB_reg_rd = pipe_we ? rd_q : REG_ZERO;
    assign wb_ready      = state == RUN;
    assign init_done     = state == RUN;
    assign retired_count = cnt_q;

    // Init writes come straight from state, so the SP write is presented while still in reset.
    always_comb begin
        state_n     = state;
        reg_write   = pipe_we;
        reg_rd_wb   = rd_q;
        reg_rd_data = sel_data;
`ifdef WB_REGFILE_CLEAR_EN
        idx_n       = idx_q;
`endif
        case (state)
            INIT_SP: begin
                reg_write   = 1'b1;
                reg_rd_wb   = SP_IDX;
                reg_rd_data = SP_RESET;
`ifdef WB_REGFILE_CLEAR_EN
                state_n     = CLEAR;
                idx_n       = 4'd1;
`else
                state_n     = RUN;
`endif
            end
`ifdef WB_REGFILE_CLEAR_EN
            CLEAR: begin
                reg_write   = 1'b1;
                reg_rd_wb   = idx_q;
                reg_rd_data = '0;
                state_n     = (idx_q == 4'd14) ? RUN : CLEAR;
                idx_n       = idx_q + 4'd1;
            end
`endif
            default: state_n = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= INIT_SP;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            m2r_q   <= 1'b0;
            call_q  <= 1'b0;
            rd_q    <= '0;
            alu_q   <= '0;
            mem_q   <= '0;
            pc_q    <= '0;
            cnt_q   <= '0;
`ifdef WB_REGFILE_CLEAR_EN
            idx_q   <= '0;
`endif
        end else begin
            state   <= state_n;
`ifdef WB_REGFILE_CLEAR_EN
            idx_q   <= idx_n;
`endif
            valid_q <= (state == RUN) && mem_valid;
            if (state == RUN && mem_valid) begin
                we_q  <= reg_write_in;
                m2r_q <= mem_to_reg_in;
                call_q <= call_in;
                rd_q  <= reg_rd_in;
                alu_q <= alu_result_in;
                mem_q <= mem_data_in;
                pc_q  <= PC_in;
            end
            if (state == RUN && valid_q && cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
        end
    end
endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit: directed self-checking bench for wb_unit.
module tb_wb_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        mem_valid = 1'b0, reg_write_in = 1'b0, mem_to_reg_in = 1'b0, call_in = 1'b0;
    logic [3:0]  reg_rd_in = '0;
    logic [15:0] alu_result_in = '0, mem_data_in = '0, PC_in = '0;
    logic        wb_ready, reg_write, init_done;
    logic [3:0]  reg_rd_wb, MEM_WB_reg_rd;
    logic [15:0] reg_rd_data, retired_count;
    int          checks = 0, failures = 0;

    wb_unit dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .wb_ready(wb_ready),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in), .call_in(call_in),
        .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in), .mem_data_in(mem_data_in),
        .PC_in(PC_in), .reg_write(reg_write), .reg_rd_wb(reg_rd_wb), .reg_rd_data(reg_rd_data),
        .MEM_WB_reg_rd(MEM_WB_reg_rd), .init_done(init_done), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic op(input logic v, input logic we, input logic m2r, input logic call,
                      input logic [3:0] rd, input logic [15:0] alu, input logic [15:0] mem,
                      input logic [15:0] pc);
        mem_valid = v; reg_write_in = we; mem_to_reg_in = m2r; call_in = call;
        reg_rd_in = rd; alu_result_in = alu; mem_data_in = mem; PC_in = pc;
    endtask

    task automatic chk_sp_write(input string tag);
        chk({tag, "_we"}, reg_write, 1);
        chk({tag, "_rd"}, reg_rd_wb, 4'hF);
        chk({tag, "_data"}, reg_rd_data, 16'hFFFF);
        chk({tag, "_ready"}, wb_ready, 0);
        chk({tag, "_done"}, init_done, 0);
        chk({tag, "_tag"}, MEM_WB_reg_rd, 0);
        chk({tag, "_cnt"}, retired_count, 0);
    endtask

    // Called right after rst rises (1 time unit after an edge); ends with wb_ready high.
    task automatic init_seq(input string tag);
        chk_sp_write({tag, "_pre_edge"});
        step();
`ifdef WB_REGFILE_CLEAR_EN
        for (int i = 1; i <= 14; i++) begin
            chk({tag, "_clr_we"}, reg_write, 1);
            chk({tag, "_clr_rd"}, reg_rd_wb, i);
            chk({tag, "_clr_data"}, reg_rd_data, 0);
            chk({tag, "_clr_ready"}, wb_ready, 0);
            step();
        end
`endif
        chk({tag, "_ready"}, wb_ready, 1);
        chk({tag, "_done"}, init_done, 1);
        chk({tag, "_no_write"}, reg_write, 0);
        chk({tag, "_tag0"}, MEM_WB_reg_rd, 0);
    endtask

    initial begin
        #1;
        chk_sp_write("reset");
        step();
        step();
        chk_sp_write("reset_hold");
        // ALU op held during init must not be captured until ready.
        op(1, 1, 0, 0, 4'h3, 16'h1234, 16'h0, 16'h0);
        rst = 1'b1;
        init_seq("init1");
        step();
        chk("alu_we", reg_write, 1);
        chk("alu_rd", reg_rd_wb, 3);
        chk("alu_data", reg_rd_data, 16'h1234);
        chk("alu_tag", MEM_WB_reg_rd, 3);
        chk("alu_cnt", retired_count, 0);
        op(1, 1, 1, 0, 4'h5, 16'h1111, 16'hBEEF, 16'h0);
        step();
        chk("load_data", reg_rd_data, 16'hBEEF);
        chk("load_rd", reg_rd_wb, 5);
        chk("load_tag", MEM_WB_reg_rd, 5);
        chk("cnt_1", retired_count, 1);
        op(1, 1, 1, 1, 4'hE, 16'h2222, 16'hBEEF, 16'hFFFF);
        step();
        chk("call_wrap_data", reg_rd_data, 16'h0000);
        chk("call_rd", reg_rd_wb, 4'hE);
        chk("call_tag", MEM_WB_reg_rd, 4'hE);
        chk("cnt_2", retired_count, 2);
        op(1, 1, 0, 0, 4'h0, 16'h5555, 16'h0, 16'h0);
        step();
        chk("r0_we", reg_write, 0);
        chk("r0_tag", MEM_WB_reg_rd, 0);
        chk("cnt_3", retired_count, 3);
        op(1, 0, 0, 0, 4'h7, 16'h6666, 16'h0, 16'h0);
        step();
        chk("nowr_we", reg_write, 0);
        chk("nowr_tag", MEM_WB_reg_rd, 0);
        chk("cnt_4", retired_count, 4);
        op(0, 1, 0, 0, 4'h8, 16'h7777, 16'h0, 16'h0);
        step();
        chk("bubble_we", reg_write, 0);
        chk("cnt_5", retired_count, 5);
        step();
        chk("bubble_cnt_hold", retired_count, 5);
        // Mid-stream reset with a pending write to r9.
        op(1, 1, 0, 0, 4'h9, 16'hABCD, 16'h0, 16'h0);
        step();
        chk("pend_we", reg_write, 1);
        chk("pend_rd", reg_rd_wb, 9);
        #2;
        rst = 1'b0;
        #1;
        chk_sp_write("midrst");
        op(0, 0, 0, 0, 4'h0, 16'h0, 16'h0, 16'h0);
        step();
        chk_sp_write("midrst_hold");
        rst = 1'b1;
        init_seq("init2");
        step();
        chk("post_init_no_pend", reg_write, 0);
        chk("post_init_cnt", retired_count, 0);
        // Saturation: stream retirements until the counter pins at FFFF.
        op(1, 1, 0, 0, 4'h1, 16'h0, 16'h0, 16'h0);
        step();
        chk("sat_start", retired_count, 0);
        repeat (65534) step();
        chk("sat_fffe", retired_count, 16'hFFFE);
        step();
        chk("sat_ffff", retired_count, 16'hFFFF);
        step();
        step();
        chk("sat_hold", retired_count, 16'hFFFF);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
